multdiv_unit: RTL and testbench

- Multi-cycle signed multiply/divide unit for the execute stage of the 5-stage pipeline.
- Accepts operands from the DX-stage operand muxes on a one-cycle start pulse.
- Iterates one bit per clock and returns a 32-bit result plus an exception flag to the XM latch input.
- Asserts busy so the hazard logic can stall FD/DX while an operation is in flight.

---
 rtl/multdiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_multdiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit, one bit per clock.
// Optional macro MULTDIV_EARLY_DONE_EN: trivial operands (multiply by 0, divide by 0) finish in one cycle.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    // Product register: {accumulator (WIDTH+1), multiplier (WIDTH), Booth guard bit}.
    // The accumulator carries one extra bit so the most-negative multiplicand stays exact.
    localparam int PW = 2 * WIDTH + 2;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PW-1:0]    prod_reg, prod_next;
    logic [WIDTH:0]   mcand_reg;
    logic [WIDTH:0]   rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] dsor_reg;
    logic             neg_reg, div0_reg, ovf_reg;
    logic [WIDTH-1:0] result_next;
    logic             exc_next;
    logic             load_result;
    logic             load_ops;

    logic             start_mul, start_div, last_iter;
    logic [WIDTH:0]   acc, acc_sum;
    logic [PW-1:0]    booth_step;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign start_mul = ctrl_MULT & ~ctrl_DIV;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign last_iter = (count_reg == CNT_W'(WIDTH - 1));

    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // One Booth step: add/subtract the multiplicand per the bit pair, then arithmetic shift.
    always_comb begin
        acc = prod_reg[PW-1 -: WIDTH+1];
        case (prod_reg[1:0])
            2'b01:   acc_sum = acc + mcand_reg;
            2'b10:   acc_sum = acc - mcand_reg;
            default: acc_sum = acc;
        endcase
        booth_step = PW'($signed({acc_sum, prod_reg[WIDTH:0]}) >>> 1);
    end

    // One restoring-division step on magnitudes; the dividend shifts out of the quotient register.
    always_comb begin
        rem_sh = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
        diff   = rem_sh - {1'b0, dsor_reg};
        if (!diff[WIDTH]) begin
            rem_step = diff;
            quo_step = {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_sh;
            quo_step = {quo_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        prod_next   = prod_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        result_next = data_result;
        exc_next    = data_exception;
        load_result = 1'b0;
        load_ops    = 1'b0;

        case (state_reg)
            MUL: begin
                prod_next  = booth_step;
                count_next = count_reg + 1'b1;
                if (last_iter) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                    result_next = booth_step[WIDTH:1];
                    exc_next    = (booth_step[2*WIDTH:WIDTH+1] != {WIDTH{booth_step[WIDTH]}});
                end
            end
            DIV: begin
                rem_next   = rem_step;
                quo_next   = quo_step;
                count_next = count_reg + 1'b1;
                if (last_iter) begin
                    state_next  = DONE;
                    load_result = 1'b1;
                    if (div0_reg) begin
                        result_next = '0;
                        exc_next    = 1'b1;
                    end else begin
                        result_next = neg_reg ? -quo_step : quo_step;
                        exc_next    = ovf_reg;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // A valid start always wins, aborting whatever is in flight.
        if (start_mul || start_div) begin
            state_next  = start_mul ? MUL : DIV;
            count_next  = '0;
            load_ops    = 1'b1;
            load_result = 1'b0;
            result_next = data_result;
            exc_next    = data_exception;
            prod_next   = {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
            rem_next    = '0;
            quo_next    = a_mag;
`ifdef MULTDIV_EARLY_DONE_EN
            if (start_mul && (data_operandA == '0 || data_operandB == '0)) begin
                state_next  = DONE;
                load_result = 1'b1;
                result_next = '0;
                exc_next    = 1'b0;
            end else if (start_div && data_operandB == '0) begin
                state_next  = DONE;
                load_result = 1'b1;
                result_next = '0;
                exc_next    = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod_reg       <= '0;
            mcand_reg      <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            dsor_reg       <= '0;
            neg_reg        <= 1'b0;
            div0_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            prod_reg <= prod_next;
            rem_reg  <= rem_next;
            quo_reg  <= quo_next;
            if (load_ops) begin
                mcand_reg <= {data_operandA[WIDTH-1], data_operandA};
                dsor_reg  <= b_mag;
                neg_reg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div0_reg  <= (data_operandB == '0);
                ovf_reg   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                             (data_operandB == {WIDTH{1'b1}});
            end
            if (load_result) begin
                data_result    <= result_next;
                data_exception <= exc_next;
            end
        end
    end

    assign data_resultRDY = (state_reg == DONE);
    assign busy           = (state_reg == MUL) || (state_reg == DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expected results queued at start, compared on each rdy pulse.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] op_a  = '0;
    logic [31:0] op_b  = '0;
    logic        cm    = 1'b0;
    logic        cd    = 1'b0;
    logic [31:0] res;
    logic        exc, rdy, busy;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          at;
        string       tag;
    } exp_t;
    exp_t sb[$];

`ifdef MULTDIV_EARLY_DONE_EN
    localparam int LAT_TRIVIAL = 1;
`else
    localparam int LAT_TRIVIAL = 33;
`endif

    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (op_a),
        .data_operandB (op_b),
        .ctrl_MULT     (cm),
        .ctrl_DIV      (cd),
        .data_result   (res),
        .data_exception(exc),
        .data_resultRDY(rdy),
        .busy          (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        vectors++;
        assert (got === want)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Independent reference: 64-bit signed product, SV signed division with the two special cases.
    function automatic void model(bit is_div, logic [31:0] a, logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        if (!is_div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = $signed(a) / $signed(b);
            e = 1'b0;
        end
    endfunction

    always @(negedge clock) begin
        if (rdy) begin
            if (sb.size() == 0) begin
                check("spurious_rdy", 32'(rdy), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_res"}, res, e.res);
                check({e.tag, "_exc"}, 32'(exc), 32'(e.exc));
                check({e.tag, "_rdy_cycle"}, 32'(cyc), 32'(e.at));
                $display("txn %s: result=%h exc=%0d at cycle %0d", e.tag, res, exc, cyc);
            end
        end
    end

    task automatic start(bit is_div, logic [31:0] a, logic [31:0] b, bit push,
                         logic [31:0] r, logic e, int lat, string tag);
        @(negedge clock);
        op_a = a;
        op_b = b;
        cm   = !is_div;
        cd   = is_div;
        if (push) sb.push_back('{r, e, cyc + lat, tag});
        @(negedge clock);
        cm   = 1'b0;
        cd   = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
    endtask

    task automatic run_model(bit is_div, logic [31:0] a, logic [31:0] b, string tag);
        logic [31:0] r;
        logic        e;
        int          lat;
        model(is_div, a, b, r, e);
        lat = 33;
`ifdef MULTDIV_EARLY_DONE_EN
        if ((!is_div && (a == 0 || b == 0)) || (is_div && b == 0)) lat = 1;
`endif
        start(is_div, a, b, 1'b1, r, e, lat, tag);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          busy_cnt;
        logic        seen;
        logic [31:0] ta[8];
        logic [31:0] tb_[8];
        bit          td[8];

        #1;
        check("reset_res", res, 32'd0);
        check("reset_exc", 32'(exc), 32'd0);
        check("reset_rdy", 32'(rdy), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        start(1'b0, 32'd7, -32'sd3, 1'b1, 32'hFFFF_FFEB, 1'b0, 33, "mul_7x-3");
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            busy_cnt += int'(busy);
            @(negedge clock);
        end
        check("mul_busy_cycles", 32'(busy_cnt), 32'd32);
        drain(40);

        start(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0, 1'b1, 33, "mul_ovf");
        drain(40);
        start(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b0, 33, "mul_max");
        drain(40);

        start(1'b1, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0, 33, "div_-7/2");
        drain(40);
        start(1'b1, 32'd100, 32'd0, 1'b1, 32'h0, 1'b1, LAT_TRIVIAL, "div_by0");
        drain(40);
        start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 33, "div_ovf");
        drain(40);
        start(1'b1, 32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 1'b0, 33, "div_min/2");
        drain(40);

        ta  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd12345, -32'sd100, 32'h8000_0000, 32'd0, 32'hDEAD_BEEF, 32'd7};
        tb_ = '{32'h8000_0000, 32'hFFFF_FFFF, -32'sd7,   -32'sd9,   32'd1,         32'd55, 32'h0000_1234, 32'd9};
        td  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            run_model(td[i], ta[i], tb_[i], $sformatf("tbl%0d", i));
            drain(40);
        end
        for (int i = 0; i < 4; i++) begin
            run_model(i[0], $urandom, $urandom_range(1, 32'h00FF_FFFF), $sformatf("rnd%0d", i));
            drain(40);
        end

        // Multiply aborted by a divide issued ten cycles later
        start(1'b0, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0, 0, "mul_aborted");
        repeat (8) @(negedge clock);
        start(1'b1, 32'd20, 32'd4, 1'b1, 32'd5, 1'b0, 33, "div_20/4");
        drain(40);

        @(negedge clock);
        cm = 1'b1;
        cd = 1'b1;
        @(negedge clock);
        cm = 1'b0;
        cd = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen |= busy | rdy;
            @(negedge clock);
        end
        check("both_starts_ignored", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a divide
        start(1'b1, 32'd1000, 32'd3, 1'b0, 32'h0, 1'b0, 0, "div_reset");
        repeat (13) @(negedge clock);
        check("busy_before_reset", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_res", res, 32'd0);
        check("async_reset_exc", 32'(exc), 32'd0);
        check("async_reset_rdy", 32'(rdy), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        start(1'b0, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0, 33, "mul_3x4");
        drain(40);
        repeat (5) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
